// File: rtl/rgb_led_pwm_ctrl.sv
// RGB LED PWM controller: per-LED colour/duty shadow registers committed at each
// PWM period boundary, with global steady, blink, breathe and off modes.
module rgb_led_pwm_ctrl #(
  parameter int  NUM_LEDS      = 2,
  parameter int  PWM_BITS      = 8,
  parameter int  BLINK_PERIODS = 64,
  localparam int IDX_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            color_sel,
  input  logic [PWM_BITS-1:0]   duty,
  input  logic [1:0]            mode,
  output logic [3*NUM_LEDS-1:0] led_out,
  output logic                  period_start
);

  localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  typedef enum logic [1:0] {
    MODE_STEADY  = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [2:0]            color_sh_q  [NUM_LEDS];
  logic [2:0]            color_sh_d  [NUM_LEDS];
  logic [PWM_BITS-1:0]   duty_sh_q   [NUM_LEDS];
  logic [PWM_BITS-1:0]   duty_sh_d   [NUM_LEDS];
  logic [2:0]            color_act_q [NUM_LEDS];
  logic [2:0]            color_act_d [NUM_LEDS];
  logic [PWM_BITS-1:0]   duty_act_q  [NUM_LEDS];
  logic [PWM_BITS-1:0]   duty_act_d  [NUM_LEDS];
  mode_e                 mode_act_q, mode_act_d, mode_req;
  logic [BC_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [PWM_BITS-1:0]   level_q, level_d;
  logic                  dir_down_q, dir_down_d;
  logic [3*NUM_LEDS-1:0] led_q, led_d;
  logic                  ps_q;
  logic                  wrap;

  function automatic logic [2:0] color_decode(input logic [3:0] sel);
    case (sel)
      4'b0001: return 3'b001;
      4'b0010: return 3'b010;
      4'b0100: return 3'b100;
      4'b1000: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Breathe scales duty by level through a full-width product, keeping the top half.
  function automatic logic [PWM_BITS-1:0] eff_duty(input logic [PWM_BITS-1:0] d,
                                                   input logic [PWM_BITS-1:0] lvl,
                                                   input logic             breathe);
    logic [2*PWM_BITS-1:0] prod;
    prod = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, lvl};
    return breathe ? prod[2*PWM_BITS-1:PWM_BITS] : d;
  endfunction

  assign wrap     = &pwm_cnt_q;
  assign mode_req = mode_e'(mode);

  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    color_sh_d  = color_sh_q;
    duty_sh_d   = duty_sh_q;
    color_act_d = color_act_q;
    duty_act_d  = duty_act_q;
    mode_act_d  = mode_act_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    level_d     = level_q;
    dir_down_d  = dir_down_q;
    if (wr_en && (int'(wr_idx) < NUM_LEDS)) begin
      color_sh_d[wr_idx] = color_decode(color_sel);
      duty_sh_d[wr_idx]  = duty;
    end
    // Commit from the already-updated shadow so a write on the wrap cycle wins.
    if (wrap) begin
      color_act_d = color_sh_d;
      duty_act_d  = duty_sh_d;
      mode_act_d  = mode_req;
      if (mode_req != mode_act_q) begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        level_d     = '0;
        dir_down_d  = 1'b0;
      end else begin
        case (mode_act_q)
          MODE_BLINK: begin
            if (blink_cnt_q == BC_W'(BLINK_PERIODS - 1)) begin
              blink_cnt_d = '0;
              blink_on_d  = ~blink_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
          MODE_BREATHE: begin
            if (!dir_down_q) begin
              level_d = level_q + 1'b1;
              if (&level_d) dir_down_d = 1'b1;
            end else begin
              level_d = level_q - 1'b1;
              if (level_d == '0) dir_down_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    logic [PWM_BITS-1:0] eff;
    logic                on;
    led_d = '0;
    eff   = '0;
    on    = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      eff = eff_duty(duty_act_q[i], level_q, mode_act_q == MODE_BREATHE);
      on  = (&eff) || (pwm_cnt_q < eff);
      if ((mode_act_q == MODE_BLINK) && !blink_on_q) on = 1'b0;
      if (mode_act_q == MODE_OFF) on = 1'b0;
      led_d[3*i +: 3] = on ? color_act_q[i] : 3'b000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q   <= '0;
      color_sh_q  <= '{default: '0};
      duty_sh_q   <= '{default: '0};
      color_act_q <= '{default: '0};
      duty_act_q  <= '{default: '0};
      mode_act_q  <= MODE_STEADY;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      level_q     <= '0;
      dir_down_q  <= 1'b0;
      led_q       <= '0;
      ps_q        <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      color_sh_q  <= color_sh_d;
      duty_sh_q   <= duty_sh_d;
      color_act_q <= color_act_d;
      duty_act_q  <= duty_act_d;
      mode_act_q  <= mode_act_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      level_q     <= level_d;
      dir_down_q  <= dir_down_d;
      led_q       <= led_d;
      ps_q        <= wrap;
    end
  end

  assign led_out      = led_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Directed bench for rgb_led_pwm_ctrl (PWM_BITS=4, BLINK_PERIODS=2); a second
// three-LED instance covers the out-of-range write index.
module tb_rgb_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, wr_en3 = 1'b0;
  logic       wr_idx = 1'b0;
  logic [1:0] wr_idx3 = 2'd0;
  logic [3:0] color_sel = 4'd0;
  logic [3:0] duty = 4'd0;
  logic [1:0] mode = 2'd0;
  logic [5:0] led_out;
  logic [8:0] led_out3;
  logic       period_start, period_start3;

  int n_checks = 0;
  int n_pass   = 0;
  int on_cnt [5];
  int col_or [5];

  rgb_led_pwm_ctrl #(.NUM_LEDS(2), .PWM_BITS(4), .BLINK_PERIODS(2)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .color_sel(color_sel),
    .duty(duty), .mode(mode), .led_out(led_out), .period_start(period_start));

  rgb_led_pwm_ctrl #(.NUM_LEDS(3), .PWM_BITS(4), .BLINK_PERIODS(2)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_idx(wr_idx3), .color_sel(color_sel),
    .duty(duty), .mode(mode), .led_out(led_out3), .period_start(period_start3));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_ps();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (period_start) return;
    end
    check("ps_wait_timeout", 0, 1);
  endtask

  task automatic write(input logic idx, input logic [3:0] c, input logic [3:0] d);
    wr_en = 1'b1; wr_idx = idx; color_sel = c; duty = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write3(input logic [1:0] idx, input logic [3:0] c, input logic [3:0] d);
    wr_en3 = 1'b1; wr_idx3 = idx; color_sel = c; duty = d;
    @(negedge clk);
    wr_en3 = 1'b0;
  endtask

  // Call on the period_start sample; the next 16 samples show one full period.
  task automatic measure(input bit mid_wr);
    int ps_cnt;
    logic [2:0] slot;
    ps_cnt = 0;
    for (int s = 0; s < 5; s++) begin on_cnt[s] = 0; col_or[s] = 0; end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int s = 0; s < 5; s++) begin
        slot = (s < 2) ? led_out[3*s +: 3] : led_out3[3*(s-2) +: 3];
        if (slot != 3'b000) on_cnt[s]++;
        col_or[s] = col_or[s] | int'(slot);
      end
      if (period_start) ps_cnt++;
      if (mid_wr && k == 7) begin
        wr_en = 1'b1; wr_idx = 1'b0; color_sel = 4'b0010; duty = 4'd15;
      end else if (k == 8) begin
        wr_en = 1'b0;
      end
    end
    check("period_start_once", ps_cnt, 1);
  endtask

  initial begin
    int first_ps;
    int lvl;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", int'(led_out), 0);
    check("rst_ps", int'(period_start), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_ps();

    // Steady: LED0 red at duty 4, LED1 dark
    write(1'b0, 4'b0001, 4'd4);
    wait_ps();
    measure(0);
    check("steady_on0", on_cnt[0], 4);
    check("steady_col0", col_or[0], 3'b001);
    check("steady_on1", on_cnt[1], 0);

    write(1'b1, 4'b0100, 4'd8);
    wait_ps();
    measure(0);
    check("led1_on", on_cnt[1], 8);
    check("led1_col", col_or[1], 3'b100);
    check("led1_on0", on_cnt[0], 4);

    write(1'b0, 4'b0001, 4'd0);
    wait_ps();
    measure(0);
    check("duty0_on0", on_cnt[0], 0);

    write(1'b0, 4'b0011, 4'd15);
    wait_ps();
    measure(0);
    check("badcol_on0", on_cnt[0], 0);

    write(1'b0, 4'b1000, 4'd15);
    wait_ps();
    measure(0);
    check("full_on0", on_cnt[0], 16);
    check("full_col0", col_or[0], 3'b111);

    // Asynchronous reset mid-period with LEDs lit
    repeat (5) @(negedge clk);
    check("prerst_led0", int'(led_out[2:0]), 3'b111);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", int'(led_out), 0);
    check("async_rst_ps", int'(period_start), 0);
    @(negedge clk);
    rst = 1'b0;
    first_ps = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (period_start) begin first_ps = k; break; end
    end
    check("rst_restart_ps", first_ps, 16);
    check("rst_led_clear", int'(led_out), 0);

    // Out-of-range index on the three-LED instance
    write3(2'd2, 4'b0100, 4'd15);
    wait_ps();
    measure(0);
    check("idx2_on", on_cnt[4], 16);
    check("idx2_col", col_or[4], 3'b100);
    write3(2'd3, 4'b1000, 4'd15);
    wait_ps();
    measure(0);
    wait_ps();
    measure(0);
    check("idx3_led2_on", on_cnt[4], 16);
    check("idx3_led2_col", col_or[4], 3'b100);
    check("idx3_led0", on_cnt[2], 0);
    check("idx3_led1", on_cnt[3], 0);

    // Blink: two periods on, two off
    mode = 2'b01;
    write(1'b0, 4'b0010, 4'd15);
    wait_ps();
    for (int p = 0; p < 5; p++) begin
      measure(0);
      check($sformatf("blink_on0_p%0d", p), on_cnt[0], (p % 4 < 2) ? 16 : 0);
      check($sformatf("blink_col0_p%0d", p), col_or[0], (p % 4 < 2) ? 3'b010 : 0);
    end

    // Breathe: triangle level 0..15..0, eff = (15*level)>>4
    mode = 2'b10;
    write(1'b0, 4'b0001, 4'd15);
    wait_ps();
    for (int p = 0; p < 33; p++) begin
      lvl = (p <= 15) ? p : ((p <= 30) ? 30 - p : p - 30);
      measure(0);
      check($sformatf("breathe_p%0d", p), on_cnt[0], (15 * lvl) >> 4);
    end

    // Write and mode change on the wrap cycle take effect together
    repeat (15) @(negedge clk);
    mode = 2'b00;
    write(1'b0, 4'b0100, 4'd4);
    check("bnd_ps", int'(period_start), 1);
    measure(0);
    check("bnd_on0", on_cnt[0], 4);
    check("bnd_col0", col_or[0], 3'b100);

    // Mid-period write only affects the following period
    measure(1);
    check("mid_on0", on_cnt[0], 4);
    check("mid_col0", col_or[0], 3'b100);
    measure(0);
    check("mid_next_on0", on_cnt[0], 16);
    check("mid_next_col0", col_or[0], 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
